// File: rtl/if_stage.sv
// if_stage: instruction fetch stage of the 16-bit pipeline.
// Owns the PC, issues one word read at a time to instruction memory over a
// req/ack handshake, buffers returned words in a small circular FIFO and
// presents {address, instruction} at the head to decode. A branch redirect
// from decode flushes the FIFO and any in-flight fetch.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/imem_addr    read request and word address (stable while req=1)
//   imem_ack/imem_data    response strobe and data, same cycle
//   ifo_valid/addr/instr  FIFO head to decode (addr=0, instr=NOP when empty)
//   ifi_stall             decode cannot take the head this cycle
//   ifi_branch/ifi_new_pc redirect strobe and target
module if_stage #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] NOP_INSTR  = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        ifo_valid,
  output logic [15:0] ifo_addr,
  output logic [15:0] ifo_instr,
  input  logic        ifi_stall,
  input  logic        ifi_branch,
  input  logic [15:0] ifi_new_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
  } entry_t;

  entry_t [FIFO_DEPTH-1:0] fifo;
  logic [PW-1:0]           head, tail;
  logic [2:0]              count, cnt_next;
  logic [15:0]             pc, drop_addr;
  state_t                  state, state_nxt;
  logic                    push, pop, room;

  assign pop      = ifo_valid & ~ifi_stall;
  assign push     = (state == WAIT) & imem_ack;
  assign cnt_next = count + 3'(push) - 3'(pop);
  // A new request is only launched when its data is guaranteed a slot,
  // which is what makes overflow impossible.
  assign room     = (cnt_next < 3'(FIFO_DEPTH));

  assign imem_req  = (state != FETCH);
  // A dropped request keeps presenting its original address until acked.
  assign imem_addr = (state == DROP) ? drop_addr : pc;
  assign ifo_valid = (count != 3'd0);
  assign ifo_addr  = ifo_valid ? fifo[head].addr  : 16'h0000;
  assign ifo_instr = ifo_valid ? fifo[head].instr : NOP_INSTR;

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: if (!ifi_branch && room) state_nxt = WAIT;
      WAIT: begin
        if (ifi_branch)    state_nxt = imem_ack ? FETCH : DROP;
        else if (imem_ack) state_nxt = room ? WAIT : FETCH;
      end
      DROP:    if (imem_ack) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      drop_addr <= '0;
    end else begin
      state <= state_nxt;
      if (ifi_branch) begin
        // Redirect wins over any push/pop this cycle.
        count <= '0;
        head  <= '0;
        tail  <= '0;
        pc    <= ifi_new_pc;
        if (state == WAIT) drop_addr <= pc;
      end else begin
        count <= cnt_next;
        if (pop) head <= (head == LAST) ? '0 : head + 1'b1;
        if (push) begin
          tail <= (tail == LAST) ? '0 : tail + 1'b1;
          pc   <= pc + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !ifi_branch && push) fifo[tail] <= '{addr: pc, instr: imem_data};
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req, imem_ack, ifo_valid, ifi_stall, ifi_branch;
  logic [15:0] imem_addr, imem_data, ifo_addr, ifo_instr, ifi_new_pc;
  logic        req2, ack2, valid2;
  logic [15:0] addr2, data2, faddr2, finstr2;
  logic        stall2 = 1'b0, branch2 = 1'b0;
  logic [15:0] new_pc2 = 16'h0000;

  int total = 0, bad = 0;
  int ws = 0, wcnt = 0;
  logic ack_force = 1'b0;

  // Memory model for dut: acks after ws wait cycles, data = addr + 0x1000.
  assign imem_ack  = (imem_req && (wcnt >= ws)) || ack_force;
  assign imem_data = imem_addr + 16'h1000;
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end
  // Zero-wait memory for dut2.
  assign ack2  = req2;
  assign data2 = addr2 + 16'h1000;

  if_stage #(.RESET_PC(16'h0000), .FIFO_DEPTH(2), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ifo_valid(ifo_valid),
    .ifo_addr(ifo_addr), .ifo_instr(ifo_instr), .ifi_stall(ifi_stall),
    .ifi_branch(ifi_branch), .ifi_new_pc(ifi_new_pc));

  if_stage #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(2), .NOP_INSTR(16'h0800)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(ack2), .imem_data(data2), .ifo_valid(valid2),
    .ifo_addr(faddr2), .ifo_instr(finstr2), .ifi_stall(stall2),
    .ifi_branch(branch2), .ifi_new_pc(new_pc2));

  // FIFO may never exceed its depth or accept a push while full.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (dut.count > 3'd2 || (dut.push && !dut.pop && dut.count == 3'd2)) begin
        bad++; $display("FAIL overflow: count=%0d push=%b pop=%b want count<=2 and no push when full",
                        dut.count, dut.push, dut.pop);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Leaves the bench in the first cycle after reset release.
  task automatic do_reset(input int w);
    rst = 1'b1; ifi_stall = 1'b0; ifi_branch = 1'b0; ifi_new_pc = 16'h0;
    ack_force = 1'b0; ws = w;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; ifi_stall = 1'b0; ifi_branch = 1'b0; ifi_new_pc = 16'h0; ws = 0;
    tick; tick;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (ifo_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ifo_valid); end
    total++; if (ifo_addr !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", ifo_addr); end
    total++; if (ifo_instr !== 16'h0800) begin bad++; $display("FAIL reset_instr: got %h want 0800", ifo_instr); end
    total++; if (req2 !== 1'b0 || valid2 !== 1'b0 || finstr2 !== 16'h0800) begin
      bad++; $display("FAIL reset_dut2: req=%b valid=%b instr=%h want 0 0 0800", req2, valid2, finstr2);
    end
  endtask

  task automatic test_zero_wait;
    do_reset(0);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_c0_req: got %b want 0", imem_req); end
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
      bad++; $display("FAIL zw_c1_req: req=%b addr=%h want 1 0000", imem_req, imem_addr);
    end
    total++; if (ifo_valid !== 1'b0) begin bad++; $display("FAIL zw_c1_valid: got %b want 0", ifo_valid); end
    for (int i = 0; i < 4; i++) begin
      tick;
      total++; if (ifo_valid !== 1'b1 || ifo_addr !== 16'(i) || ifo_instr !== 16'h1000 + 16'(i)) begin
        bad++; $display("FAIL zw_head%0d: valid=%b addr=%h instr=%h want 1 %h %h",
                        i, ifo_valid, ifo_addr, ifo_instr, 16'(i), 16'h1000 + 16'(i));
      end
    end
  endtask

  task automatic test_wait_states;
    int exp_a, last_c;
    logic prev_req, prev_ack;
    logic [15:0] prev_addr;
    exp_a = 0; last_c = -1; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 16'h0;
    do_reset(3);
    for (int c = 1; c <= 24; c++) begin
      tick;
      if (prev_req && !prev_ack && imem_req) begin
        total++; if (imem_addr !== prev_addr) begin
          bad++; $display("FAIL ws_addr_stable c%0d: got %h want %h", c, imem_addr, prev_addr);
        end
      end
      if (ifo_valid) begin
        total++; if (ifo_addr !== 16'(exp_a) || ifo_instr !== 16'h1000 + 16'(exp_a)) begin
          bad++; $display("FAIL ws_seq c%0d: addr=%h instr=%h want %h %h",
                          c, ifo_addr, ifo_instr, 16'(exp_a), 16'h1000 + 16'(exp_a));
        end
        total++;
        if ((last_c < 0 && c != 5) || (last_c >= 0 && c - last_c != 4)) begin
          bad++; $display("FAIL ws_spacing: valid at c%0d prev c%0d want first c5 then every 4", c, last_c);
        end
        last_c = c; exp_a++;
      end
      prev_req = imem_req; prev_ack = imem_ack; prev_addr = imem_addr;
    end
    total++; if (exp_a != 5) begin bad++; $display("FAIL ws_count: got %0d want 5", exp_a); end
  endtask

  task automatic test_stall;
    do_reset(0);
    ifi_stall = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c >= 3) begin
        total++; if (imem_req !== 1'b0 || ifo_valid !== 1'b1 || ifo_addr !== 16'h0 || ifo_instr !== 16'h1000) begin
          bad++; $display("FAIL stall_hold c%0d: req=%b valid=%b addr=%h instr=%h want 0 1 0000 1000",
                          c, imem_req, ifo_valid, ifo_addr, ifo_instr);
        end
      end
    end
    ifi_stall = 1'b0;
    tick;
    total++; if (ifo_addr !== 16'h1 || imem_req !== 1'b1 || imem_addr !== 16'h2) begin
      bad++; $display("FAIL stall_release: head=%h req=%b iaddr=%h want 0001 1 0002", ifo_addr, imem_req, imem_addr);
    end
    tick;
    total++; if (ifo_valid !== 1'b1 || ifo_addr !== 16'h2) begin
      bad++; $display("FAIL stall_resume: valid=%b head=%h want 1 0002", ifo_valid, ifo_addr);
    end
  endtask

  task automatic test_branch;
    bit found;
    found = 1'b0;
    do_reset(2);
    for (int c = 0; c < 40 && !found; c++) begin
      tick;
      if (imem_req && imem_addr == 16'h5) found = 1'b1;
    end
    total++; if (!found) begin bad++; $display("FAIL br_reach5: request to 0005 not seen, want seen"); end
    if (found) begin
      ifi_new_pc = 16'h0040; ifi_branch = 1'b1;
      tick;
      ifi_branch = 1'b0;
      for (int c = 0; c < 2; c++) begin
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h5 || ifo_valid !== 1'b0) begin
          bad++; $display("FAIL br_drop%0d: req=%b addr=%h valid=%b want 1 0005 0", c, imem_req, imem_addr, ifo_valid);
        end
        tick;
      end
      total++; if (imem_req !== 1'b0 || ifo_valid !== 1'b0) begin
        bad++; $display("FAIL br_fetch: req=%b valid=%b want 0 0", imem_req, ifo_valid);
      end
      tick;
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
        bad++; $display("FAIL br_target_req: req=%b addr=%h want 1 0040", imem_req, imem_addr);
      end
      tick; tick;
      total++; if (ifo_valid !== 1'b0) begin bad++; $display("FAIL br_empty: valid=%b want 0", ifo_valid); end
      tick;
      total++; if (ifo_valid !== 1'b1 || ifo_addr !== 16'h0040 || ifo_instr !== 16'h1040) begin
        bad++; $display("FAIL br_first_head: valid=%b addr=%h instr=%h want 1 0040 1040", ifo_valid, ifo_addr, ifo_instr);
      end
    end
  endtask

  task automatic test_branch_ack_stall;
    do_reset(0);
    ifi_stall = 1'b1;
    tick; tick;
    total++; if (ifo_valid !== 1'b1 || ifo_addr !== 16'h0 || imem_ack !== 1'b1 || imem_addr !== 16'h1) begin
      bad++; $display("FAIL bas_setup: valid=%b head=%h ack=%b iaddr=%h want 1 0000 1 0001",
                      ifo_valid, ifo_addr, imem_ack, imem_addr);
    end
    ifi_new_pc = 16'h0080; ifi_branch = 1'b1;
    tick;
    ifi_branch = 1'b0;
    total++; if (ifo_valid !== 1'b0 || imem_req !== 1'b0 || ifo_instr !== 16'h0800) begin
      bad++; $display("FAIL bas_flush: valid=%b req=%b instr=%h want 0 0 0800", ifo_valid, imem_req, ifo_instr);
    end
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
      bad++; $display("FAIL bas_target: req=%b addr=%h want 1 0080", imem_req, imem_addr);
    end
    tick;
    total++; if (ifo_valid !== 1'b1 || ifo_addr !== 16'h0080) begin
      bad++; $display("FAIL bas_head: valid=%b addr=%h want 1 0080", ifo_valid, ifo_addr);
    end
    ifi_stall = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    do_reset(3);
    tick; tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0 || imem_ack !== 1'b0) begin
      bad++; $display("FAIL rmw_wait: req=%b addr=%h ack=%b want 1 0000 0", imem_req, imem_addr, imem_ack);
    end
    rst = 1'b1;
    tick;
    total++; if (imem_req !== 1'b0 || ifo_valid !== 1'b0) begin
      bad++; $display("FAIL rmw_drop_req: req=%b valid=%b want 0 0", imem_req, ifo_valid);
    end
    ack_force = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    ack_force = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0 || ifo_valid !== 1'b0) begin
      bad++; $display("FAIL rmw_restart: req=%b addr=%h valid=%b want 1 0000 0", imem_req, imem_addr, ifo_valid);
    end
    for (int c = 6; c <= 8; c++) begin
      tick;
      total++; if (ifo_valid !== 1'b0) begin bad++; $display("FAIL rmw_ignored c%0d: valid=%b want 0", c, ifo_valid); end
    end
    tick;
    total++; if (ifo_valid !== 1'b1 || ifo_addr !== 16'h0 || ifo_instr !== 16'h1000) begin
      bad++; $display("FAIL rmw_head: valid=%b addr=%h instr=%h want 1 0000 1000", ifo_valid, ifo_addr, ifo_instr);
    end
  endtask

  task automatic test_pc_wrap;
    logic [15:0] e;
    do_reset(0);
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      e = 16'hFFFE + 16'(i);
      total++; if (valid2 !== 1'b1 || faddr2 !== e || finstr2 !== e + 16'h1000) begin
        bad++; $display("FAIL wrap%0d: valid=%b addr=%h instr=%h want 1 %h %h", i, valid2, faddr2, finstr2, e, e + 16'h1000);
      end
    end
  endtask

  initial begin
    ifi_stall = 1'b0; ifi_branch = 1'b0; ifi_new_pc = 16'h0;
    test_reset;
    test_zero_wait;
    test_wait_states;
    test_stall;
    test_branch;
    test_branch_ack_stall;
    test_reset_mid_wait;
    test_pc_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the 16-bit pipeline, directly upstream of the decode stage.
- Owns the PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO and presents {address, instruction} to decode.
- Accepts branch redirects (target and strobe) from decode, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 16'h0000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; legal range 1..4.
- NOP_INSTR, 16'h0800, instruction word driven on ifo_instr while ifo_valid=0.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  16  word address of the request; stable while imem_req=1.
- imem_ack  in  1  memory response strobe; imem_data is valid in the same cycle.
- imem_data  in  16  instruction word returned.
- ifo_valid  out  1  FIFO head is valid.
- ifo_addr  out  16  word address of the head instruction (feeds decode idi_addr).
- ifo_instr  out  16  head instruction (feeds decode idi_instr).
- ifi_stall  in  1  decode cannot accept the head this cycle.
- ifi_branch  in  1  redirect strobe from decode (ido_branch).
- ifi_new_pc  in  16  redirect target (ido_new_pc); used only when ifi_branch=1.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and rst.
- Reset state: pc=RESET_PC, FIFO count=0, state=FETCH, imem_req=0, ifo_valid=0, ifo_addr=0, ifo_instr=NOP_INSTR.
- Reset mid-request abandons the request; the memory must tolerate a dropped req. imem_ack during reset is ignored.
- FSM states:
  - FETCH: no request outstanding.
  - WAIT: one request outstanding at pc.
  - DROP: one request outstanding whose data must be discarded.
- imem_req=1 exactly in WAIT and DROP; imem_addr=pc in WAIT; in DROP imem_addr holds the abandoned address.
- Definitions:
  - pop = ifo_valid & ~ifi_stall.
  - push = (state==WAIT) & imem_ack.
  - cnt_next = count + push - pop.
- FETCH -> WAIT when cnt_next < FIFO_DEPTH; otherwise stay in FETCH.
- WAIT with imem_ack:
  - write {pc, imem_data} at the FIFO tail; pc <= pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
  - next state WAIT if cnt_next < FIFO_DEPTH, else FETCH. Back-to-back fetch is one instruction per cycle with zero-wait memory.
- WAIT without imem_ack: hold state, pc and imem_addr.
- DROP with imem_ack: discard data, go to FETCH. Without ack: stay in DROP.
- imem_ack while imem_req=0 is ignored.
- Latency: first cycle after reset release is FETCH; imem_req rises the next cycle; with same-cycle ack, ifo_valid=1 the cycle after ack.
- A pushed entry is visible at the head no earlier than the cycle after the push (no bypass).
- Branch (ifi_branch=1 at an edge) overrides push/pop/count updates:
  - count <= 0 and pc <= ifi_new_pc.
  - From WAIT without ack: go to DROP.
  - From WAIT with ack: data is dropped; go to FETCH.
  - From FETCH or DROP: stay or return in the same state (DROP stays DROP until its ack).
- The head popped in the branch cycle is the branch instruction itself. Delay-slot handling belongs to decode.
- ifi_branch and ifi_stall together: the branch still takes effect.
- Full FIFO with ifi_stall=1: no new request issued; head and all entries are held stable.
- Empty FIFO: ifo_valid=0; outputs default (ifo_addr=0, ifo_instr=NOP_INSTR). A stall while empty has no effect.
- FIFO is a circular buffer with head/tail pointers mod FIFO_DEPTH. Overflow is impossible by construction; the bench must assert it.

Test Plan:
- Reset, then zero-wait memory returning data=addr+16'h1000, ifi_stall=0 -> imem_req rises 1 cycle after reset release; ifo_valid the cycle after; ifo_addr sequence 0,1,2,3 on consecutive cycles with ifo_instr 16'h1000..16'h1003.
- Memory with 3 wait states -> exactly one instruction per 4 cycles; imem_addr stable while imem_req=1; no duplicate or skipped address.
- ifi_stall=1 for 10 cycles, FIFO_DEPTH=2 -> two entries buffered, imem_req drops, head unchanged. Stall release pops addr 0 then 1, and fetching resumes at 2.
- ifi_branch=1, ifi_new_pc=16'h0040 while a request to 16'h0005 is outstanding (ack 2 cycles later) -> data for 0005 discarded, FIFO empty; next request to 0040; first valid head is ifo_addr=0040.
- ifi_branch coinciding with imem_ack and ifi_stall=1 -> acked data not pushed; ifo_valid=0 next cycle; next imem_addr=new target.
- RESET_PC=16'hFFFE, free-running -> ifo_addr sequence FFFE, FFFF, 0000, 0001.
- Reset asserted while in WAIT -> imem_req=0 next cycle; later ack ignored; fetch restarts at RESET_PC.
